// File: rtl/hamming_secded_pkg.sv
// Shared types and helpers for the SECDED-protected scrub counter.
// Each 4-bit data block carries check bits {p3, p2, p1, p0}, where p3 is the overall parity.
package hamming_secded_pkg;

    // Controller states, kept as plain constants for compatibility with older tooling.
    typedef logic [1:0] state_e;
    localparam state_e StIdle   = 2'd0;
    localparam state_e StCount  = 2'd1;
    localparam state_e StEncode = 2'd2;
    localparam state_e StScrub  = 2'd3;

    // Outcome of decoding one block.
    typedef enum logic [1:0] {
        DecOk,
        DecSingleD,
        DecSingleP,
        DecDouble
    } dec_kind_e;

    // idx is the data bit (DecSingleD) or check bit (DecSingleP) to flip.
    typedef struct packed {
        dec_kind_e  kind;
        logic [1:0] idx;
    } dec_result_t;

    // Hamming(7,4) parity bits {p2, p1, p0}.
    function automatic logic [2:0] secded_par3(input logic [3:0] d);
        return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
    endfunction

    // Full check word {p3, p2, p1, p0}; p3 makes the 8-bit codeword even parity.
    function automatic logic [3:0] secded_enc(input logic [3:0] d);
        logic [2:0] p;
        p = secded_par3(d);
        return {^{d, p}, p};
    endfunction

endpackage

// File: rtl/secded_84_dec.sv
// Combinational SECDED(8,4) decoder for one block: corrects a single flipped bit,
// flags two flipped bits and leaves the word untouched in that case.
module secded_84_dec (
    input  logic [3:0] data_in,
    input  logic [3:0] check_in,
    output logic [3:0] data_out,
    output logic [3:0] check_out,
    output logic       single,
    output logic       dbl
);
    import hamming_secded_pkg::*;

    logic [2:0]  syn;
    logic        overall;
    dec_result_t res;

    // Classify the error from syndrome and overall parity, then apply the single-bit fix.
    always_comb begin
        syn      = check_in[2:0] ^ secded_par3(data_in);
        overall  = ^{data_in, check_in};
        res.kind = DecOk;
        res.idx  = 2'd0;
        if (overall) begin
            unique case (syn)
                3'b000: res = '{kind: DecSingleP, idx: 2'd3};
                3'b001: res = '{kind: DecSingleP, idx: 2'd0};
                3'b010: res = '{kind: DecSingleP, idx: 2'd1};
                3'b100: res = '{kind: DecSingleP, idx: 2'd2};
                3'b111: res = '{kind: DecSingleD, idx: 2'd0};
                3'b011: res = '{kind: DecSingleD, idx: 2'd1};
                3'b101: res = '{kind: DecSingleD, idx: 2'd2};
                3'b110: res = '{kind: DecSingleD, idx: 2'd3};
            endcase
        end else if (syn != 3'b000) begin
            res.kind = DecDouble;
        end

        data_out  = data_in;
        check_out = check_in;
        if (res.kind == DecSingleD) begin
            data_out[res.idx] = ~data_in[res.idx];
        end
        if (res.kind == DecSingleP) begin
            check_out[res.idx] = ~check_in[res.idx];
        end
        single = (res.kind == DecSingleD) || (res.kind == DecSingleP);
        dbl    = (res.kind == DecDouble);
    end

endmodule

// File: rtl/hamming_secded_scrub_counter.sv
// Free-running counter whose value is SECDED-protected while idle. Counting leaves the
// check bits stale; dropping enable re-encodes every block, after which a scrubber walks
// one block per cycle, correcting single errors in place and flagging doubles.
module hamming_secded_scrub_counter #(
    parameter  int WIDTH  = 128,
    parameter  int CNT_W  = 16,
    localparam int BLOCKS = WIDTH / 4,
    localparam int IDX_W  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             inject_en,
    input  logic [IDX_W-1:0] inject_idx,
    output logic [WIDTH-1:0] counter,
    output logic             busy,
    output logic             protected_o,
    output logic             corr_pulse,
    output logic             uncorr,
    output logic [CNT_W-1:0] corr_count
);
    import hamming_secded_pkg::*;

    localparam int PTR_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int CHK_W = 4 * BLOCKS;

    if ((WIDTH % 4) != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of 4");
    end

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [CHK_W-1:0] check_q, check_d;
    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             protected_q, protected_d;
    logic             corr_pulse_q, corr_pulse_d;
    logic             uncorr_q, uncorr_d;
    logic [CNT_W-1:0] corr_count_q, corr_count_d;

    logic [3:0]  blk_data, blk_check, fix_data, fix_check;
    logic        fix_single, fix_dbl;
    logic [31:0] idx_ext, ptr_ext;

    assign idx_ext = 32'(inject_idx);
    assign ptr_ext = 32'(ptr_q);

    // Select the block currently under the scrub pointer.
    always_comb begin
        blk_data  = '0;
        blk_check = '0;
        for (int b = 0; b < BLOCKS; b++) begin
            if (ptr_ext == 32'(b)) begin
                blk_data  = counter_q[4*b +: 4];
                blk_check = check_q[4*b +: 4];
            end
        end
    end

    secded_84_dec u_dec (
        .data_in   (blk_data),
        .check_in  (blk_check),
        .data_out  (fix_data),
        .check_out (fix_check),
        .single    (fix_single),
        .dbl       (fix_dbl)
    );

    // Next-state: clear beats enable beats scrub; injection lands after any correction.
    always_comb begin
        counter_d    = counter_q;
        check_d      = check_q;
        state_d      = state_q;
        ptr_d        = ptr_q;
        protected_d  = protected_q;
        corr_pulse_d = 1'b0;
        uncorr_d     = uncorr_q;
        corr_count_d = corr_count_q;

        if (clear) begin
            counter_d    = '0;
            check_d      = '0;
            state_d      = StIdle;
            ptr_d        = '0;
            protected_d  = 1'b0;
            uncorr_d     = 1'b0;
            corr_count_d = '0;
        end else begin
            if (enable) begin
                // Aborts any scrub in progress; the block under the pointer is not written.
                counter_d   = counter_q + 1'b1;
                state_d     = StCount;
                protected_d = 1'b0;
            end else begin
                case (state_q)
                    StCount: state_d = StEncode;
                    StEncode: begin
                        for (int b = 0; b < BLOCKS; b++) begin
                            check_d[4*b +: 4] = secded_enc(counter_q[4*b +: 4]);
                        end
                        state_d = StScrub;
                        ptr_d   = '0;
                    end
                    default: begin
                        // StIdle and StScrub both scrub; only completion of a pass differs.
                        for (int b = 0; b < BLOCKS; b++) begin
                            if (ptr_ext == 32'(b)) begin
                                counter_d[4*b +: 4] = fix_data;
                                check_d[4*b +: 4]   = fix_check;
                            end
                        end
                        if (fix_single) begin
                            corr_pulse_d = 1'b1;
                            if (corr_count_q != '1) begin
                                corr_count_d = corr_count_q + 1'b1;
                            end
                        end
                        if (fix_dbl) begin
                            uncorr_d = 1'b1;
                        end
                        if (ptr_q == PTR_W'(BLOCKS - 1)) begin
                            ptr_d       = '0;
                            protected_d = 1'b1;
                            state_d     = StScrub;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                endcase
            end

            for (int i = 0; i < WIDTH; i++) begin
                if (inject_en && idx_ext == 32'(i)) begin
                    counter_d[i] = ~counter_d[i];
                end
            end
            for (int j = 0; j < CHK_W; j++) begin
                if (inject_en && idx_ext == 32'(WIDTH + j)) begin
                    check_d[j] = ~check_d[j];
                end
            end
        end
    end

    // State registers; all-zero check bits are a valid codeword for a zero counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q    <= '0;
            check_q      <= '0;
            state_q      <= StIdle;
            ptr_q        <= '0;
            protected_q  <= 1'b0;
            corr_pulse_q <= 1'b0;
            uncorr_q     <= 1'b0;
            corr_count_q <= '0;
        end else begin
            counter_q    <= counter_d;
            check_q      <= check_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            protected_q  <= protected_d;
            corr_pulse_q <= corr_pulse_d;
            uncorr_q     <= uncorr_d;
            corr_count_q <= corr_count_d;
        end
    end

    assign counter     = counter_q;
    assign busy        = (state_q == StEncode) || ((state_q == StScrub) && !protected_q);
    assign protected_o = protected_q;
    assign corr_pulse  = corr_pulse_q;
    assign uncorr      = uncorr_q;
    assign corr_count  = corr_count_q;

endmodule

// File: tb/tb_hamming_secded_scrub_counter.sv
// Randomised scoreboard bench for the SECDED scrub counter at WIDTH=16.
module tb_hamming_secded_scrub_counter;

    localparam int W  = 16;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          inject_en = 1'b0;
    logic [IW-1:0] inject_idx = '0;
    logic [W-1:0]  counter;
    logic          busy, protected_o, corr_pulse, uncorr;
    logic [15:0]   corr_count;

    hamming_secded_scrub_counter #(
        .WIDTH (W),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .inject_en   (inject_en),
        .inject_idx  (inject_idx),
        .counter     (counter),
        .busy        (busy),
        .protected_o (protected_o),
        .corr_pulse  (corr_pulse),
        .uncorr      (uncorr),
        .corr_count  (corr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] cnt;
        logic [15:0]  corr;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] model_cnt = '0;
    logic [15:0]  model_corr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic count(input int n);
        enable = 1'b1;
        repeat (n) tick();
        enable = 1'b0;
        model_cnt = model_cnt + n[W-1:0];
    endtask

    task automatic wait_protected();
        for (int i = 0; i < 20 && !protected_o; i++) tick();
        check("protected_wait", {31'd0, protected_o}, 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 16) begin
            tick();
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL corr_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // Any single flip while protected must be undone, with exactly one correction pulse.
    task automatic single_inject(input int idx);
        exp_t         e;
        logic [W-1:0] flipped;
        model_corr++;
        e.cnt  = model_cnt;
        e.corr = model_corr;
        sb.push_back(e);
        flipped = model_cnt;
        if (idx < W) flipped[idx] = ~flipped[idx];
        inject_idx = idx[IW-1:0];
        inject_en  = 1'b1;
        tick();
        inject_en = 1'b0;
        check("inject_visible", {16'd0, counter}, {16'd0, flipped});
        wait_drain();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_cnt  = '0;
        model_corr = '0;
    endtask

    // Monitor: every correction pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && corr_pulse) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_corr_pulse counter=0x%0h required=no pulse", counter);
            end else begin
                mon_e = sb.pop_front();
                check("corr_counter", {16'd0, counter}, {16'd0, mon_e.cnt});
                check("corr_count", {16'd0, corr_count}, {16'd0, mon_e.corr});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check("rst_counter", {16'd0, counter}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_protected", {31'd0, protected_o}, 32'd0);
        check("rst_pulse", {31'd0, corr_pulse}, 32'd0);
        check("rst_uncorr", {31'd0, uncorr}, 32'd0);
        check("rst_corr_count", {16'd0, corr_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Count 37, then encode and one full scrub pass.
        count(37);
        check("t1_counter", {16'd0, counter}, 32'h25);
        check("t1_count_prot", {31'd0, protected_o}, 32'd0);
        check("t1_count_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t1_encode_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1_scrub_busy", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        check("t1_prot_early", {31'd0, protected_o}, 32'd0);
        tick();
        check("t1_prot", {31'd0, protected_o}, 32'd1);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        check("t1_uncorr", {31'd0, uncorr}, 32'd0);

        // Data bit 9, then p3 of block 2.
        single_inject(9);
        single_inject(W + 4 * 2 + 3);
        check("t3_counter", {16'd0, counter}, 32'h25);
        check("t3_uncorr", {31'd0, uncorr}, 32'd0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                count($urandom_range(1, 200));
                wait_protected();
            end
            single_inject($urandom_range(0, 2 * W - 1));
        end
        check("rand_uncorr", {31'd0, uncorr}, 32'd0);
        check("rand_counter", {16'd0, counter}, {16'd0, model_cnt});

        // Double error in block 1: after encode the scrubber visits block 1 on the fourth edge.
        do_clear();
        check("clr_counter", {16'd0, counter}, 32'd0);
        check("clr_corr_count", {16'd0, corr_count}, 32'd0);
        count(37);
        repeat (3) tick();
        inject_en  = 1'b1;
        inject_idx = 5'd4;
        tick();
        inject_idx = 5'd5;
        tick();
        inject_en = 1'b0;
        repeat (8) tick();
        check("t4_uncorr", {31'd0, uncorr}, 32'd1);
        check("t4_counter", {16'd0, counter}, 32'h15);
        check("t4_corr_count", {16'd0, corr_count}, {16'd0, model_corr});
        repeat (8) tick();
        check("t4_uncorr_sticky", {31'd0, uncorr}, 32'd1);
        do_clear();
        check("t4_clr_uncorr", {31'd0, uncorr}, 32'd0);

        // Wraparound and abort of a scrub pass.
        count(65535);
        check("t5_max", {16'd0, counter}, 32'hFFFF);
        count(1);
        check("t5_wrap", {16'd0, counter}, 32'h0);
        repeat (3) tick();
        check("t5_mid_busy", {31'd0, busy}, 32'd1);
        count(1);
        check("t5_abort_prot", {31'd0, protected_o}, 32'd0);
        check("t5_abort_cnt", {16'd0, counter}, {16'd0, model_cnt});
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        tick();
        wait_protected();
        count(1);
        check("t5_abort2_prot", {31'd0, protected_o}, 32'd0);
        tick();
        wait_protected();

        // Asynchronous reset mid-scrub.
        single_inject($urandom_range(0, 2 * W - 1));
        #3 rst = 1'b1;
        #1;
        check("t6_rst_counter", {16'd0, counter}, 32'd0);
        check("t6_rst_prot", {31'd0, protected_o}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_corr_count", {16'd0, corr_count}, 32'd0);
        check("t6_rst_uncorr", {31'd0, uncorr}, 32'd0);
        tick();
        rst = 1'b0;
        model_cnt  = '0;
        model_corr = '0;
        tick();

        // Clear must swallow a same-cycle inject, for a data bit and for a check bit.
        for (int r = 0; r < 2; r++) begin
            count(5);
            tick();
            wait_protected();
            clear      = 1'b1;
            inject_en  = 1'b1;
            inject_idx = (r == 0) ? 5'd0 : 5'd17;
            tick();
            clear     = 1'b0;
            inject_en = 1'b0;
            model_cnt  = '0;
            model_corr = '0;
            check("t6_clr_counter", {16'd0, counter}, 32'd0);
            repeat (10) tick();
            check("t6_clr_counter_late", {16'd0, counter}, 32'd0);
            check("t6_clr_corr_count", {16'd0, corr_count}, 32'd0);
            check("t6_clr_uncorr", {31'd0, uncorr}, 32'd0);
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
